// File: rtl/snn_cost_pkg.sv
// Shared helpers for the SNN output-layer cost evaluator: saturating accumulate, magnitude, rotation.
package snn_cost_pkg;

  localparam int MAX_W = 64;

  typedef logic signed [1:0] diff_t;

  // Symmetric saturation at +/-(2^(acc_w-1)-1) keeps abs() representable in acc_w-1 bits.
  function automatic int sat_add(input int acc, input int d, input int acc_w);
    int lim;
    int s;
    lim = (1 << (acc_w - 1)) - 1;
    s   = acc + d;
    if (s > lim) begin
      s = lim;
    end else if (s < -lim) begin
      s = -lim;
    end
    return s;
  endfunction

  function automatic int abs_mag(input int acc);
    return (acc < 0) ? -acc : acc;
  endfunction

  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] word, input int n,
                                            input int rw);
    logic [MAX_W-1:0] m;
    logic [MAX_W-1:0] w;
    int               s;
    m = (rw >= MAX_W) ? '1 : ((64'd1 << rw) - 64'd1);
    w = word & m;
    s = n % rw;
    return ((w << s) | (w >> (rw - s))) & m;
  endfunction

endpackage

// File: rtl/snn_cost_eval_if.sv
// Stream bundle between the last SNN layer, the cost evaluator and the L3 update logic.
// ERR_COUNT and its CNT_W parameter exist only when SNN_COST_ERRCNT_EN is defined.
interface snn_cost_eval_if #(
  parameter int N_OUT = 5,
  parameter int RW    = 8
`ifdef SNN_COST_ERRCNT_EN
  , parameter int CNT_W = 16
`endif
);

  logic [N_OUT-1:0] Y;
  logic [N_OUT-1:0] A_OUT;
  logic [RW-1:0]    R;
  logic [N_OUT-1:0] EPS;
  logic [N_OUT-1:0] SIGN;
  logic             VALID;
`ifdef SNN_COST_ERRCNT_EN
  logic [CNT_W-1:0] ERR_COUNT;
`endif

  modport master (
    output Y, A_OUT, R,
    input  EPS, SIGN, VALID
`ifdef SNN_COST_ERRCNT_EN
    , input ERR_COUNT
`endif
  );

  modport slave (
    input  Y, A_OUT, R,
    output EPS, SIGN, VALID
`ifdef SNN_COST_ERRCNT_EN
    , output ERR_COUNT
`endif
  );

endinterface

// File: rtl/snn_err_chan.sv
// One output channel: saturating signed error accumulator, sign register and stochastic
// magnitude comparator. SIGN and eps_raw are taken from the pre-update accumulator.
module snn_err_chan #(
  parameter int ACC_W = 8
) (
  input  logic             CLK,
  input  logic             i_clr,
  input  logic             i_y,
  input  logic             i_a,
  input  logic [ACC_W-2:0] i_r,
  output logic             o_sign,
  output logic             o_eps_raw
);
  import snn_cost_pkg::*;

  localparam int MW = ACC_W - 1;

  logic signed [ACC_W-1:0] r_acc;
  logic                    r_sign_p1;
  logic                    r_eps_raw_p1;
  diff_t                   w_d;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic [MW-1:0]           w_mag;

  assign w_d       = diff_t'({1'b0, i_y}) - diff_t'({1'b0, i_a});
  assign w_acc_nxt = ACC_W'(sat_add(int'(r_acc), int'(w_d), ACC_W));
  assign w_mag     = MW'(abs_mag(int'(r_acc)));

  // stage p1: accumulate, register sign and comparator result
  always_ff @(posedge CLK) begin
    if (i_clr) begin
      r_acc        <= '0;
      r_sign_p1    <= 1'b0;
      r_eps_raw_p1 <= 1'b0;
    end else begin
      r_acc        <= w_acc_nxt;
      r_sign_p1    <= r_acc[ACC_W-1];
      r_eps_raw_p1 <= (w_mag > i_r);
    end
  end

  assign o_sign    = r_sign_p1;
  assign o_eps_raw = r_eps_raw_p1;

endmodule

// File: rtl/snn_cost_eval.sv
// Output-layer cost evaluator: per-channel error estimates, settling suppression and EPS/SIGN output.
// Optional per-epoch error counter ERR_COUNT enabled by defining SNN_COST_ERRCNT_EN.
module snn_cost_eval #(
  parameter int N_OUT         = 5,
  parameter int ACC_W         = 8,
  parameter int RW            = 8,
  parameter int SUPPRESS_TIME = 8
`ifdef SNN_COST_ERRCNT_EN
  , parameter int CNT_W       = 16
`endif
) (
  input  logic            CLK,
  input  logic            INIT,
  input  logic            TRAIN_FLAG,
  snn_cost_eval_if.slave  bus
);
  import snn_cost_pkg::*;

  localparam int MW = ACC_W - 1;
  localparam int SW = $clog2(SUPPRESS_TIME + 2);

  logic             w_clr;
  logic [SW-1:0]    r_sup_cnt;
  logic             w_valid;
  logic [N_OUT-1:0] w_eps_raw;
  logic [N_OUT-1:0] w_sign;

  assign w_clr = INIT | TRAIN_FLAG;

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_chan
    logic [MW-1:0] w_r;

    // Each channel compares against a differently rotated copy of the shared random word.
    assign w_r = MW'(rotl(MAX_W'(bus.R), gi, RW));

    snn_err_chan #(
      .ACC_W (ACC_W)
    ) u_chan (
      .CLK       (CLK),
      .i_clr     (w_clr),
      .i_y       (bus.Y[gi]),
      .i_a       (bus.A_OUT[gi]),
      .i_r       (w_r),
      .o_sign    (w_sign[gi]),
      .o_eps_raw (w_eps_raw[gi])
    );
  end

  // stage p1: settling counter, stops one past SUPPRESS_TIME
  always_ff @(posedge CLK) begin
    if (w_clr) begin
      r_sup_cnt <= '0;
    end else if (r_sup_cnt <= SW'(SUPPRESS_TIME)) begin
      r_sup_cnt <= r_sup_cnt + SW'(1);
    end
  end

  assign w_valid   = (r_sup_cnt > SW'(SUPPRESS_TIME));
  assign bus.VALID = w_valid;
  assign bus.SIGN  = w_sign;
  assign bus.EPS   = w_valid ? w_eps_raw : '0;

`ifdef SNN_COST_ERRCNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  // Only INIT clears the counter so it spans all samples of an epoch.
  always_ff @(posedge CLK) begin
    if (INIT) begin
      r_err_cnt <= '0;
    end else if (w_valid && (|w_eps_raw) && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign bus.ERR_COUNT = r_err_cnt;
`else
`endif

endmodule

// File: tb/tb_snn_cost_eval.sv
// Randomised self-checking bench for snn_cost_eval against a cycle-level arithmetic model.
module tb_snn_cost_eval;

  localparam int N_OUT   = 5;
  localparam int ACC_W   = 8;
  localparam int RW      = 8;
  localparam int ST      = 8;
  localparam int CNT_W   = 16;
  localparam int LIM     = (1 << (ACC_W - 1)) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic INIT = 1'b0;
  logic TRAIN_FLAG = 1'b0;

  always #5 CLK = ~CLK;

  snn_cost_eval_if #(
    .N_OUT (N_OUT),
    .RW    (RW)
`ifdef SNN_COST_ERRCNT_EN
    , .CNT_W (CNT_W)
`endif
  ) bus ();

  snn_cost_eval #(
    .N_OUT         (N_OUT),
    .ACC_W         (ACC_W),
    .RW            (RW),
    .SUPPRESS_TIME (ST)
`ifdef SNN_COST_ERRCNT_EN
    , .CNT_W       (CNT_W)
`endif
  ) dut (
    .CLK        (CLK),
    .INIT       (INIT),
    .TRAIN_FLAG (TRAIN_FLAG),
    .bus        (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: signed error per channel, cycles since clear, last-registered outputs.
  int               m_acc [N_OUT];
  int               m_sup = 0;
  logic [N_OUT-1:0] m_eps_raw = '0;
  logic [N_OUT-1:0] m_sign = '0;
  int               m_cnt = 0;

  function automatic int rot_low(input logic [RW-1:0] w, input int i);
    int v;
    v = 0;
    for (int k = 0; k < ACC_W - 1; k++) begin
      if (w[(k - (i % RW) + RW) % RW]) v += (1 << k);
    end
    return v;
  endfunction

  function automatic logic exp_valid();
    return m_sup > ST;
  endfunction

  function automatic logic [N_OUT-1:0] exp_eps();
    return (m_sup > ST) ? m_eps_raw : '0;
  endfunction

  task automatic drive(input logic [N_OUT-1:0] y, input logic [N_OUT-1:0] a,
                       input logic [RW-1:0] r, input logic init, input logic tf);
    bus.Y      = y;
    bus.A_OUT  = a;
    bus.R      = r;
    INIT       = init;
    TRAIN_FLAG = tf;
  endtask

  task automatic tick();
    logic clr;
    int   mag;
    @(posedge CLK);
    clr = INIT | TRAIN_FLAG;
    if (INIT) m_cnt = 0;
    else if (exp_valid() && (m_eps_raw != '0) && (m_cnt < CNT_MAX)) m_cnt++;
    for (int i = 0; i < N_OUT; i++) begin
      if (clr) begin
        m_acc[i]     = 0;
        m_sign[i]    = 1'b0;
        m_eps_raw[i] = 1'b0;
      end else begin
        mag          = (m_acc[i] < 0) ? -m_acc[i] : m_acc[i];
        m_sign[i]    = (m_acc[i] < 0);
        m_eps_raw[i] = (mag > rot_low(bus.R, i));
        m_acc[i]     = m_acc[i] + int'(bus.Y[i]) - int'(bus.A_OUT[i]);
        if (m_acc[i] > LIM) m_acc[i] = LIM;
        if (m_acc[i] < -LIM) m_acc[i] = -LIM;
      end
    end
    if (clr) m_sup = 0;
    else if (m_sup <= ST) m_sup++;
    #1;
  endtask

  task automatic test_reset();
    drive(N_OUT'($urandom), N_OUT'($urandom), RW'($urandom), 1'b1, 1'b0);
    tick();
    n_vec++;
    if (bus.VALID !== 1'b0) begin
      n_err++; $display("FAIL reset_valid got %b want 0", bus.VALID);
    end
    n_vec++;
    if (bus.EPS !== '0) begin
      n_err++; $display("FAIL reset_eps got %b want 00000", bus.EPS);
    end
    n_vec++;
    if (bus.SIGN !== '0) begin
      n_err++; $display("FAIL reset_sign got %b want 00000", bus.SIGN);
    end
`ifdef SNN_COST_ERRCNT_EN
    n_vec++;
    if (bus.ERR_COUNT !== '0) begin
      n_err++; $display("FAIL reset_errcnt got %0d want 0", bus.ERR_COUNT);
    end
`endif
  endtask

  task automatic test_suppression();
    logic             want_v;
    logic [N_OUT-1:0] want_e;
    drive('0, '0, '0, 1'b1, 1'b0);
    tick();
    drive(5'h01, '0, '0, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      want_v = (k >= ST + 1);
      want_e = want_v ? 5'h01 : 5'h00;
      n_vec++;
      if (bus.VALID !== want_v || bus.EPS !== want_e || bus.SIGN !== '0) begin
        n_err++;
        $display("FAIL suppress_edge%0d got v=%b eps=%b sign=%b want v=%b eps=%b sign=00000",
                 k, bus.VALID, bus.EPS, bus.SIGN, want_v, want_e);
      end
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 200; k++) begin
      drive('0, 5'h02, RW'($urandom_range(0, 8'h7E)), 1'b0, 1'b0);
      tick();
      n_vec++;
      if ({bus.VALID, bus.SIGN, bus.EPS} !== {exp_valid(), m_sign, exp_eps()}) begin
        n_err++;
        $display("FAIL sat_cycle%0d got v=%b sign=%b eps=%b want v=%b sign=%b eps=%b", k,
                 bus.VALID, bus.SIGN, bus.EPS, exp_valid(), m_sign, exp_eps());
      end
    end
    drive('0, 5'h02, '0, 1'b0, 1'b0);
    tick();
    n_vec++;
    if (bus.SIGN[1] !== 1'b1 || bus.EPS[1] !== 1'b1) begin
      n_err++;
      $display("FAIL sat_ch1 got sign=%b eps=%b want sign=1 eps=1", bus.SIGN[1], bus.EPS[1]);
    end
  endtask

  task automatic test_threshold();
    drive('0, '0, '0, 1'b1, 1'b0);
    tick();
    drive(5'h01, '0, '0, 1'b0, 1'b0);
    repeat (10) tick();
    drive(5'h1F, 5'h1F, 8'h0A, 1'b0, 1'b0);
    tick();
    n_vec++;
    if (bus.VALID !== 1'b1 || bus.EPS !== 5'h00) begin
      n_err++;
      $display("FAIL thresh_eq got v=%b eps=%b want v=1 eps=00000", bus.VALID, bus.EPS);
    end
    drive(5'h1F, 5'h1F, 8'h09, 1'b0, 1'b0);
    tick();
    n_vec++;
    if (bus.EPS !== 5'h01) begin
      n_err++; $display("FAIL thresh_gt got eps=%b want 00001", bus.EPS);
    end
  endtask

  task automatic test_train_flag();
    int edges;
    for (int k = 0; k < 20; k++) begin
      drive(N_OUT'($urandom), N_OUT'($urandom), RW'($urandom), 1'b0, 1'b0);
      tick();
      n_vec++;
      if ({bus.VALID, bus.SIGN, bus.EPS} !== {exp_valid(), m_sign, exp_eps()}) begin
        n_err++;
        $display("FAIL tf_pre%0d got v=%b sign=%b eps=%b want v=%b sign=%b eps=%b", k,
                 bus.VALID, bus.SIGN, bus.EPS, exp_valid(), m_sign, exp_eps());
      end
    end
    drive(N_OUT'($urandom), N_OUT'($urandom), RW'($urandom), 1'b0, 1'b1);
    tick();
    n_vec++;
    if (bus.VALID !== 1'b0 || bus.EPS !== '0 || bus.SIGN !== '0) begin
      n_err++;
      $display("FAIL tf_clear got v=%b eps=%b sign=%b want v=0 eps=00000 sign=00000",
               bus.VALID, bus.EPS, bus.SIGN);
    end
    edges = -1;
    for (int e = 1; e <= 20; e++) begin
      drive(N_OUT'($urandom), N_OUT'($urandom), RW'($urandom), 1'b0, 1'b0);
      tick();
      if (bus.VALID === 1'b1) begin
        edges = e;
        break;
      end
    end
    n_vec++;
    if (edges != ST + 1) begin
      n_err++; $display("FAIL tf_valid_return got %0d edges want %0d", edges, ST + 1);
    end
  endtask

  task automatic test_rotation();
    drive('0, '0, '0, 1'b1, 1'b0);
    tick();
    drive(5'h1F, '0, RW'($urandom), 1'b0, 1'b0);
    tick();
    drive('0, '0, 8'h01, 1'b0, 1'b0);
    repeat (10) tick();
    n_vec++;
    if (bus.VALID !== 1'b1 || bus.EPS !== 5'b00000) begin
      n_err++;
      $display("FAIL rot_acc1 got v=%b eps=%b want v=1 eps=00000", bus.VALID, bus.EPS);
    end
    drive(5'h1F, '0, 8'h01, 1'b0, 1'b0);
    repeat (2) tick();
    drive('0, '0, 8'h01, 1'b0, 1'b0);
    tick();
    n_vec++;
    if (bus.EPS !== 5'b00011) begin
      n_err++; $display("FAIL rot_acc3 got eps=%b want 00011", bus.EPS);
    end
  endtask

  task automatic test_random();
    logic init;
    logic tf;
    for (int k = 0; k < 400; k++) begin
      init = ($urandom_range(0, 63) == 0);
      tf   = ($urandom_range(0, 31) == 0);
      drive(N_OUT'($urandom), N_OUT'($urandom), RW'($urandom), init, tf);
      tick();
      n_vec++;
      if ({bus.VALID, bus.SIGN, bus.EPS} !== {exp_valid(), m_sign, exp_eps()}) begin
        n_err++;
        $display("FAIL rand_cycle%0d got v=%b sign=%b eps=%b want v=%b sign=%b eps=%b", k,
                 bus.VALID, bus.SIGN, bus.EPS, exp_valid(), m_sign, exp_eps());
      end
`ifdef SNN_COST_ERRCNT_EN
      n_vec++;
      if (bus.ERR_COUNT !== CNT_W'(m_cnt)) begin
        n_err++;
        $display("FAIL rand_errcnt%0d got %0d want %0d", k, bus.ERR_COUNT, m_cnt);
      end
`endif
    end
  endtask

`ifdef SNN_COST_ERRCNT_EN
  task automatic test_errcnt();
    drive('0, '0, '0, 1'b1, 1'b0);
    tick();
    drive(5'h01, '0, '0, 1'b0, 1'b0);
    repeat (ST + 21) tick();
    n_vec++;
    if (bus.ERR_COUNT !== CNT_W'(20)) begin
      n_err++; $display("FAIL errcnt_20 got %0d want 20", bus.ERR_COUNT);
    end
    drive(5'h01, '0, '0, 1'b0, 1'b1);
    tick();
    n_vec++;
    if (bus.ERR_COUNT !== CNT_W'(m_cnt) || bus.ERR_COUNT < CNT_W'(20)) begin
      n_err++; $display("FAIL errcnt_tf_keep got %0d want %0d", bus.ERR_COUNT, m_cnt);
    end
    drive(5'h01, '0, '0, 1'b1, 1'b0);
    tick();
    n_vec++;
    if (bus.ERR_COUNT !== '0) begin
      n_err++; $display("FAIL errcnt_init got %0d want 0", bus.ERR_COUNT);
    end
    drive(5'h01, '0, '0, 1'b0, 1'b0);
    repeat (CNT_MAX + ST + 10) tick();
    n_vec++;
    if (bus.ERR_COUNT !== '1) begin
      n_err++; $display("FAIL errcnt_sat got %h want ffff", bus.ERR_COUNT);
    end
    repeat (3) tick();
    n_vec++;
    if (bus.ERR_COUNT !== '1) begin
      n_err++; $display("FAIL errcnt_sat_hold got %h want ffff", bus.ERR_COUNT);
    end
  endtask
`endif

  initial begin
    #20_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N_OUT; i++) m_acc[i] = 0;
    drive('0, '0, '0, 1'b0, 1'b0);
    test_reset();
    test_suppression();
    test_saturation();
    test_threshold();
    test_train_flag();
    test_rotation();
    test_random();
`ifdef SNN_COST_ERRCNT_EN
    test_errcnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
